id_stage: RTL and testbench

//  Instruction-decode stage feeding EXE. Accepts 32-bit instructions from fetch and splits fields.

---
 rtl/id_stage_pkg.sv | 53 +++++
 rtl/id_stage_reg_file.sv | 34 +++
 rtl/id_stage.sv | 102 ++++++++++
 tb/tb_id_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage and the EXE/ALU side:
// instruction field positions, ALU opcodes and the decoded-field record.
package id_stage_pkg;

    localparam int REG_IDX_W = 4;
    localparam int INSTR_W   = 32;

    // Instruction field bit positions
    localparam int OP_BIT  = 31;
    localparam int OC_HI   = 30;
    localparam int OC_LO   = 28;
    localparam int RD_HI   = 27;
    localparam int RD_LO   = 24;
    localparam int RS1_HI  = 23;
    localparam int RS1_LO  = 20;
    localparam int RS2_HI  = 19;
    localparam int RS2_LO  = 16;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;

    // ALU opcodes, shared with EXE
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic                 ir_op;
        alu_op_e              alu_oc;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [15:0]          imm;
    } instr_t;

    function automatic instr_t decode(input logic [INSTR_W-1:0] ins);
        instr_t d;
        d.ir_op  = ins[OP_BIT];
        d.alu_oc = alu_op_e'(ins[OC_HI:OC_LO]);
        d.rd     = ins[RD_HI:RD_LO];
        d.rs1    = ins[RS1_HI:RS1_LO];
        d.rs2    = ins[RS2_HI:RS2_LO];
        d.imm    = ins[IMM_HI:IMM_LO];
        return d;
    endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// Architectural register file: two async read ports, one sync write port.
// R0 always reads zero and ignores writes.
module id_stage_reg_file
    import id_stage_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int XLEN  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] ra1,
    input  logic [REG_IDX_W-1:0] ra2,
    output logic [XLEN-1:0]      rd1,
    output logic [XLEN-1:0]      rd2,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] wa,
    input  logic [XLEN-1:0]      wd
);

    logic [NREGS-1:0][XLEN-1:0] regs;

    // Register storage; index 0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: splits fields, reads operands (with writeback
// bypass), sign-extends the immediate and registers the bundle toward EXE.
// A pending-write scoreboard holds fetch off on RAW/WAW hazards.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int XLEN  = 32,
    parameter int IMM_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      value1,
    output logic [XLEN-1:0]      value2,
    output logic [XLEN-1:0]      immediate,
    output logic [2:0]           alu_oc,
    output logic                 ir_op,
    output logic [REG_IDX_W-1:0] rd,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_addr,
    input  logic [XLEN-1:0]      wb_data
);

    instr_t            d;
    logic [XLEN-1:0]   rf_rd1, rf_rd2;
    logic [XLEN-1:0]   op1, op2, imm_ext;
    logic [NREGS-1:0]  pend, wb_clr, pend_eff, pend_nxt;
    logic              hazard, fire;

    assign d = decode(instr);

    id_stage_reg_file #(.NREGS(NREGS), .XLEN(XLEN)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (d.rs1),
        .ra2   (d.rs2),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (wb_en),
        .wa    (wb_addr),
        .wd    (wb_data)
    );

    // Writeback retires its register before the hazard check of the same cycle
    always_comb begin
        wb_clr = '0;
        if (wb_en) wb_clr[wb_addr] = 1'b1;
    end

    assign pend_eff = pend & ~wb_clr;
    // rs2 only matters when operand2 actually comes from the register file
    assign hazard   = pend_eff[d.rs1] | (d.ir_op & pend_eff[d.rs2]) | pend_eff[d.rd];
    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign fire     = in_valid && in_ready;

    // Next scoreboard: a new producer's set wins over a same-cycle writeback clear
    always_comb begin
        pend_nxt = pend_eff;
        if (fire && d.rd != '0) pend_nxt[d.rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= '0;
        else        pend <= pend_nxt;
    end

    // Operand read with bypass from the writeback port seen in the fire cycle
    assign op1     = (wb_en && wb_addr == d.rs1 && d.rs1 != '0) ? wb_data : rf_rd1;
    assign op2     = (wb_en && wb_addr == d.rs2 && d.rs2 != '0) ? wb_data : rf_rd2;
    assign imm_ext = {{(XLEN-IMM_W){d.imm[IMM_W-1]}}, d.imm[IMM_W-1:0]};

    // Output bundle register: loads on fire, holds under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            value1    <= '0;
            value2    <= '0;
            immediate <= '0;
            alu_oc    <= '0;
            ir_op     <= 1'b0;
            rd        <= '0;
        end else if (fire) begin
            out_valid <= 1'b1;
            value1    <= op1;
            value2    <= op2;
            immediate <= imm_ext;
            alu_oc    <= d.alu_oc;
            ir_op     <= d.ir_op;
            rd        <= d.rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: expected bundles are queued when an
// instruction fires and compared when EXE consumes the bundle.
module tb_id_stage;
    import id_stage_pkg::*;

    localparam int XLEN = 32;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic             in_valid = 1'b0, out_ready = 1'b1, wb_en = 1'b0;
    logic             in_ready, out_valid, ir_op;
    logic [31:0]      instr = '0;
    logic [XLEN-1:0]  value1, value2, immediate, wb_data = '0;
    logic [2:0]       alu_oc;
    logic [3:0]       rd, wb_addr = '0;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .value1(value1), .value2(value2), .immediate(immediate),
        .alu_oc(alu_oc), .ir_op(ir_op), .rd(rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v1, v2, imm;
        logic [2:0]  oc;
        logic        op;
        logic [3:0]  rd;
    } exp_t;

    exp_t        exp_q[$];
    int          out_cyc[$];
    int          checks = 0, failures = 0, n_out = 0, cyc = 0;
    logic [31:0] model_regs [16];

    function automatic logic [31:0] mk(input logic op, input logic [2:0] oc,
                                       input logic [3:0] d, input logic [3:0] s1,
                                       input logic [3:0] s2, input logic [15:0] imm);
        return {op, oc, d, s1, s2, imm};
    endfunction

    // Reference expectation from the bench's own register model and wb inputs
    function automatic exp_t expect_of(input logic [31:0] ins);
        exp_t e;
        logic [3:0] s1, s2;
        s1 = ins[23:20];
        s2 = ins[19:16];
        e.v1  = (wb_en && wb_addr == s1 && s1 != 0) ? wb_data : model_regs[s1];
        e.v2  = (wb_en && wb_addr == s2 && s2 != 0) ? wb_data : model_regs[s2];
        e.imm = {{16{ins[15]}}, ins[15:0]};
        e.oc  = ins[30:28];
        e.op  = ins[31];
        e.rd  = ins[27:24];
        return e;
    endfunction

    // Register model and cycle counter
    always @(posedge clk) begin
        cyc++;
        if (rst_n && wb_en && wb_addr != 0) model_regs[wb_addr] = wb_data;
    end

    // Scoreboard: compare each consumed bundle against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            out_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL bundle_unexpected rd=%0d v1=%h required no bundle", rd, value1);
            end else begin
                e = exp_q.pop_front();
                if (value1 !== e.v1 || value2 !== e.v2 || immediate !== e.imm ||
                    alu_oc !== e.oc || ir_op !== e.op || rd !== e.rd) begin
                    failures++;
                    $display("FAIL bundle got v1=%h v2=%h imm=%h oc=%0d op=%b rd=%0d required v1=%h v2=%h imm=%h oc=%0d op=%b rd=%0d",
                             value1, value2, immediate, alu_oc, ir_op, rd,
                             e.v1, e.v2, e.imm, e.oc, e.op, e.rd);
                end
            end
        end
    end

    // All tasks start and end at 1 time unit after a rising edge
    task automatic send(input logic [31:0] ins);
        int n = 0;
        in_valid = 1'b1;
        instr    = ins;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL send_timeout instr=%h in_ready=%b required 1", ins, in_ready);
        end else begin
            exp_q.push_back(expect_of(ins));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_wb(input logic [3:0] a, input logic [31:0] dat);
        wb_en = 1'b1; wb_addr = a; wb_data = dat;
        @(posedge clk); #1;
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 1; i < 16; i++) do_wb(4'(i), 32'hA500_0000 + i);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = mk(1'b0, ALU_SUB, 4'd5, 4'd1, 4'd0, 16'h0011);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        for (int i = 0; i < 16; i++) model_regs[i] = '0;
        checks++;
        if (out_valid !== 1'b0 || value1 !== '0 || value2 !== '0 || immediate !== '0 ||
            alu_oc !== 3'd0 || ir_op !== 1'b0 || rd !== 4'd0) begin
            failures++;
            $display("FAIL reset_outputs vld=%b v1=%h v2=%h imm=%h oc=%0d op=%b rd=%0d required all 0",
                     out_valid, value1, value2, immediate, alu_oc, ir_op, rd);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        for (int i = 1; i < 16; i++) send(mk(1'b1, ALU_ADD, 4'd0, 4'(i), 4'(i), 16'h0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_imm_decode();
        send(mk(1'b0, 3'b010, 4'd2, 4'd0, 4'd0, 16'hFFFE));
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || immediate !== 32'hFFFF_FFFE || alu_oc !== 3'd2 ||
            ir_op !== 1'b0 || rd !== 4'd2) begin
            failures++;
            $display("FAIL imm_decode vld=%b imm=%h oc=%0d op=%b rd=%0d required 1 fffffffe 2 0 2",
                     out_valid, immediate, alu_oc, ir_op, rd);
        end
        @(posedge clk); #1;
        send(mk(1'b0, ALU_SLT, 4'd0, 4'd0, 4'd0, 16'h8000));
        @(negedge clk);
        checks++;
        if (immediate !== 32'hFFFF_8000) begin
            failures++;
            $display("FAIL imm_sign_8000 imm=%h required ffff8000", immediate);
        end
        @(posedge clk); #1;
        do_wb(4'd2, 32'h0000_0022);
    endtask

    task automatic test_raw_stall();
        exp_t e;
        send(mk(1'b0, ALU_ADD, 4'd3, 4'd0, 4'd0, 16'h0001));
        in_valid = 1'b1;
        instr    = mk(1'b0, ALU_ADD, 4'd4, 4'd3, 4'd0, 16'h0005);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL raw_stall in_ready=%b required 0", in_ready);
            end
        end
        @(posedge clk); #1;
        wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'h0000_1234;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL raw_release in_ready=%b required 1", in_ready);
        end else begin
            e.v1 = 32'h0000_1234; e.v2 = 32'h0; e.imm = 32'h5;
            e.oc = ALU_ADD; e.op = 1'b0; e.rd = 4'd4;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wb_en    = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || value1 !== 32'h0000_1234 || rd !== 4'd4) begin
            failures++;
            $display("FAIL raw_bypass vld=%b v1=%h rd=%0d required 1 00001234 4", out_valid, value1, rd);
        end
        @(posedge clk); #1;
        do_wb(4'd4, 32'h0000_0044);
    endtask

    task automatic test_backpressure();
        int n0;
        out_ready = 1'b0;
        send(mk(1'b0, ALU_OR, 4'd5, 4'd0, 4'd0, 16'h0055));
        in_valid = 1'b1;
        instr    = mk(1'b0, ALU_XOR, 4'd6, 4'd0, 4'd0, 16'h0066);
        n0 = n_out;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || rd !== 4'd5 || immediate !== 32'h55) begin
                failures++;
                $display("FAIL bp_hold in_ready=%b vld=%b rd=%0d imm=%h required 0 1 5 00000055",
                         in_ready, out_valid, rd, immediate);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release in_ready=%b required 1", in_ready);
        end else begin
            exp_q.push_back(expect_of(instr));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (n_out - n0 != 2) begin
            failures++;
            $display("FAIL bp_count bundles=%0d required 2", n_out - n0);
        end
        @(posedge clk); #1;
        do_wb(4'd5, 32'h55);
        do_wb(4'd6, 32'h66);
    endtask

    task automatic test_r0_irop();
        exp_t e;
        do_wb(4'd7, 32'h0000_0077);
        send(mk(1'b0, ALU_ADD, 4'd7, 4'd0, 4'd0, 16'h0007));
        in_valid = 1'b1;
        instr    = mk(1'b1, ALU_ADD, 4'd8, 4'd0, 4'd7, 16'h0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rs2_stall in_ready=%b required 0", in_ready);
        end
        @(posedge clk); #1;
        instr = mk(1'b0, ALU_SUB, 4'd8, 4'd0, 4'd7, 16'h0008);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL irop0_no_stall in_ready=%b required 1", in_ready);
        end else begin
            exp_q.push_back(expect_of(instr));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        send(mk(1'b0, ALU_AND, 4'd0, 4'd0, 4'd0, 16'h0001));
        wb_en = 1'b1; wb_addr = 4'd0; wb_data = 32'hDEAD_BEEF;
        in_valid = 1'b1;
        instr    = mk(1'b1, ALU_ADD, 4'd0, 4'd0, 4'd0, 16'h0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rd0_no_pend in_ready=%b required 1", in_ready);
        end else begin
            e.v1 = 32'h0; e.v2 = 32'h0; e.imm = 32'h0;
            e.oc = ALU_ADD; e.op = 1'b1; e.rd = 4'd0;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wb_en    = 1'b0;
        send(mk(1'b1, ALU_OR, 4'd0, 4'd0, 4'd0, 16'h0));
        do_wb(4'd7, 32'h0000_0707);
        do_wb(4'd8, 32'h0000_0808);
    endtask

    task automatic test_back_to_back();
        int n0;
        do_wb(4'd9, 32'h0000_9999);
        do_wb(4'd10, 32'h0000_AAAA);
        @(posedge clk); #1;
        out_cyc.delete();
        n0 = n_out;
        for (int i = 0; i < 8; i++)
            send(mk(1'b1, 3'(i), 4'(i + 1), 4'd9, 4'd10, 16'(i * 273)));
        repeat (3) @(negedge clk);
        checks++;
        if (n_out - n0 != 8 || out_cyc.size() != 8) begin
            failures++;
            $display("FAIL b2b_count bundles=%0d required 8", n_out - n0);
        end else begin
            checks++;
            if (out_cyc[7] - out_cyc[0] != 7) begin
                failures++;
                $display("FAIL b2b_span cycles=%0d required 7", out_cyc[7] - out_cyc[0] + 1 - 1);
            end
        end
        @(posedge clk); #1;
        for (int i = 1; i <= 8; i++) do_wb(4'(i), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) model_regs[i] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_imm_decode();
        test_raw_stall();
        test_backpressure();
        test_r0_irop();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover pending=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
